// File: rtl/zmod_dac_sample_feeder_pkg.sv
// zmod_dac_pkg: shared widths, FSM state type and 16->14 bit round/saturate conversion
package zmod_dac_pkg;
  localparam int DAC_W = 14;
  localparam int IN_W = 16;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  function automatic logic signed [DAC_W-1:0] sat_round_16to14(input logic signed [IN_W-1:0] x);
    logic [IN_W:0] s;
    logic [DAC_W:0] y;
    s = {x[IN_W-1], x} + (IN_W+1)'(2);
    y = s[IN_W:2];
    return y[DAC_W] == y[DAC_W-1] ? y[DAC_W-1:0] : {y[DAC_W], {(DAC_W-1){~y[DAC_W]}}};
  endfunction
endpackage

// File: rtl/zmod_dac_sample_feeder_if.sv
// zmod_dac_sample_feeder_if: valid/ready stream of packed I/Q words ([15:0] = I, [31:16] = Q)
interface zmod_dac_sample_feeder_if;
  import zmod_dac_pkg::*;
  logic [2*IN_W-1:0] tdata;
  logic tvalid;
  logic tready;
  modport master(output tdata, output tvalid, input tready);
  modport slave(input tdata, input tvalid, output tready);
endinterface

// File: rtl/zmod_dac_sample_feeder_fifo.sv
// zmod_sync_fifo: single-clock first-word-fall-through FIFO
//   push/din write when not full; pop advances head when not empty; flush empties it.
//   dout always shows the head entry; level = occupancy (0..2**AW).
module zmod_sync_fifo #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [DW-1:0] mem_q [2**AW];
  logic [AW:0] wp_q, rp_q;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push && !full) wp_q <= wp_q + 1'b1;
      if (pop && !empty) rp_q <= rp_q + 1'b1;
    end
  end
  always_ff @(posedge clk) if (push && !full) mem_q[wp_q[AW-1:0]] <= din;
  assign level = wp_q - rp_q;
  assign full = level[AW];
  assign empty = level == '0;
  assign dout = mem_q[rp_q[AW-1:0]];
endmodule

// File: rtl/zmod_dac_sample_feeder.sv
// zmod_dac_sample_feeder: buffers I/Q stream, paces samples out and converts them to 14-bit for the AD9717 driver
//   clk, rst            : DAC sample clock, sync active-high reset
//   i_enable            : playback enable, low stops and flushes
//   s_axis              : I/Q input stream (slave)
//   i16_rate_div        : output period minus 1 in clk cycles
//   i_clr_underrun      : clears the sticky underrun flag (a same-cycle set wins)
//   os14_data_i/q       : converted samples, o_run: high in RUN, o_underrun, o_level: FIFO occupancy
module zmod_dac_sample_feeder
  import zmod_dac_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int PREFILL = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  zmod_dac_sample_feeder_if.slave s_axis,
  input  logic [15:0]             i16_rate_div,
  input  logic                    i_clr_underrun,
  output logic signed [DAC_W-1:0] os14_data_i,
  output logic signed [DAC_W-1:0] os14_data_q,
  output logic                    o_run,
  output logic                    o_underrun,
  output logic [FIFO_AW:0]        o_level
);
  localparam logic [FIFO_AW:0] PF = PREFILL[FIFO_AW:0];
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic signed [DAC_W-1:0] di_q, di_d, dq_q, dq_d;
  logic und_q, und_d;
  logic full, empty, flush, push, pop, tick;
  logic [2*IN_W-1:0] head;
  logic [FIFO_AW:0] level;
  zmod_sync_fifo #(.AW(FIFO_AW), .DW(2*IN_W)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .din(s_axis.tdata), .dout(head), .full(full), .empty(empty), .level(level)
  );
  assign s_axis.tready = state_q != IDLE && !full;
  assign push = s_axis.tvalid && s_axis.tready;
  // A disable edge flushes; the FIFO gives flush priority, so a word accepted then is dropped
  assign flush = state_q == IDLE || !i_enable;
  assign tick = state_q == RUN && i_enable && cnt_q == '0;
  assign pop = tick && !empty;
  always_comb begin
    state_d = !i_enable ? IDLE : state_q == IDLE ? FILL : (state_q == FILL && level >= PF) ? RUN : state_q;
    cnt_d = state_q != RUN ? '0 : tick ? i16_rate_div : cnt_q - 16'd1;
    di_d = flush ? '0 : tick ? (empty ? '0 : sat_round_16to14(head[IN_W-1:0])) : di_q;
    dq_d = flush ? '0 : tick ? (empty ? '0 : sat_round_16to14(head[2*IN_W-1:IN_W])) : dq_q;
    und_d = (tick && empty) ? 1'b1 : i_clr_underrun ? 1'b0 : und_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      di_q <= '0;
      dq_q <= '0;
      und_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      di_q <= di_d;
      dq_q <= dq_d;
      und_q <= und_d;
    end
  end
  assign os14_data_i = di_q;
  assign os14_data_q = dq_q;
  assign o_run = state_q == RUN;
  assign o_underrun = und_q;
  assign o_level = level;
endmodule

// File: tb/tb_zmod_dac_sample_feeder.sv
// tb_zmod_dac_sample_feeder: directed checks of prefill, pacing, conversion, backpressure, underrun and disable
module tb_zmod_dac_sample_feeder;
  logic clk = 1'b0;
  logic rst, en, clr;
  logic [15:0] rate;
  logic signed [13:0] di, dq;
  logic o_run, und;
  logic [4:0] lvl;
  int nchk = 0;
  int nerr = 0;
  int idx, n;
  logic acc, seen_full;
  logic [15:0] vals [8] = '{16'h7FFF, 16'h7FFC, 16'h0005, 16'h0006, 16'h8000, 16'hFFFD, 16'hFFFE, 16'h0100};
  int exps [7] = '{8191, 8191, 1, 2, -8192, -1, 0};
  zmod_dac_sample_feeder_if bus ();
  zmod_dac_sample_feeder #(.FIFO_AW(4), .PREFILL(8)) dut (
    .clk(clk), .rst(rst), .i_enable(en), .s_axis(bus), .i16_rate_div(rate),
    .i_clr_underrun(clr), .os14_data_i(di), .os14_data_q(dq), .o_run(o_run),
    .o_underrun(und), .o_level(lvl)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] word(input int k);
    logic [15:0] a;
    a = 16'(k * 4);
    return {-a, a};
  endfunction
  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; rate = 16'd0;
    bus.tvalid = 1'b0; bus.tdata = '0;
    repeat (3) step();
    chk("rst_run", o_run, 0);
    chk("rst_und", und, 0);
    chk("rst_tready", bus.tready, 0);
    chk("rst_level", lvl, 0);
    chk("rst_di", di, 0);
    chk("rst_dq", dq, 0);
    rst = 1'b0; en = 1'b1;
    step();
    chk("t1_fill_tready", bus.tready, 1);
    bus.tdata = {16'hFF00, 16'h0100}; bus.tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t1_run_pre", o_run, 0);
      step();
    end
    chk("t1_level8", lvl, 8);
    chk("t1_run_at8", o_run, 0);
    bus.tvalid = 1'b0;
    step();
    chk("t1_run_rise", o_run, 1);
    chk("t1_di_before", di, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_di", di, 64);
      chk("t1_dq", dq, -64);
      chk("t1_und_low", und, 0);
    end
    step();
    chk("t1_di_underrun", di, 0);
    chk("t1_dq_underrun", dq, 0);
    chk("t1_und_set", und, 1);
    chk("t1_level0", lvl, 0);
    clr = 1'b1; rate = 16'd3;
    step();
    chk("t5_set_wins", und, 1);
    step();
    chk("t5_clear", und, 0);
    clr = 1'b0; en = 1'b0;
    step();
    chk("t5_idle_run", o_run, 0);
    chk("t5_und_kept", und, 0);
    idx = 1; en = 1'b1; bus.tvalid = 1'b1; bus.tdata = word(idx); n = 0;
    while (!o_run && n < 40) begin
      acc = bus.tready;
      step();
      if (acc) begin idx++; bus.tdata = word(idx); end
      n++;
    end
    chk("t2_run_start", o_run, 1);
    seen_full = 1'b0;
    for (int j = 0; j < 40; j++) begin
      acc = bus.tready;
      step();
      if (acc) begin idx++; bus.tdata = word(idx); end
      chk("t2_di", di, j / 4 + 1);
      chk("t2_dq", dq, -(j / 4 + 1));
      chk("t2_und", und, 0);
      chk("t4_tready", bus.tready, lvl != 5'd16);
      if (lvl == 5'd16) seen_full = 1'b1;
    end
    chk("t4_full_seen", seen_full, 1);
    bus.tvalid = 1'b0; n = 0;
    while (lvl != 5'd5 && n < 100) begin step(); n++; end
    chk("t6_level5", lvl, 5);
    en = 1'b0;
    step();
    chk("t6_run", o_run, 0);
    chk("t6_level", lvl, 0);
    chk("t6_di", di, 0);
    chk("t6_dq", dq, 0);
    chk("t6_tready", bus.tready, 0);
    en = 1'b1;
    step();
    chk("t6_refill_tready", bus.tready, 1);
    bus.tvalid = 1'b1;
    repeat (7) step();
    bus.tvalid = 1'b0;
    step();
    chk("t6_level7", lvl, 7);
    chk("t6_no_run7", o_run, 0);
    bus.tvalid = 1'b1;
    step();
    bus.tvalid = 1'b0;
    chk("t6_level8", lvl, 8);
    chk("t6_no_run8", o_run, 0);
    step();
    chk("t6_run_again", o_run, 1);
    en = 1'b0; rate = 16'd0;
    step();
    en = 1'b1;
    step();
    bus.tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.tdata = {vals[i], vals[i]};
      step();
    end
    bus.tvalid = 1'b0;
    step();
    chk("t3_run", o_run, 1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t3_conv_i", di, exps[i]);
      chk("t3_conv_q", dq, exps[i]);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
